// File: rtl/seqdiv_pkg.sv
// Shared control-loop definitions: FSM encoding and arm/fin handshake notes.
// arm is a level request: high starts and holds an operation, low aborts and
// clears fin on the next edge. fin stays high until arm falls.
package seqdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ITER = ST_ITER,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/seqdiv_twos_abs.sv
// Conditional two's-complement negate; with neg tied to the sign bit it yields
// the unsigned magnitude (most-negative value maps to itself as unsigned).
module twos_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/seqdiv.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per cycle, then a sign fix-up pass. Truncates toward zero.
module seqdiv
  import seqdiv_pkg::*;
#(
  parameter int DIVIDEND_LEN = 32,
  parameter int DIVISOR_LEN  = 32,
  parameter int CNT_SIZ      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic [DIVIDEND_LEN-1:0] dividend,
  input  logic [DIVISOR_LEN-1:0]  divisor,
  output logic [DIVIDEND_LEN-1:0] quot,
  output logic [DIVISOR_LEN-1:0]  rem,
  output logic                    div_zero,
  output logic                    ovf,
  output logic                    fin
);

  state_t                  state;
  logic [CNT_SIZ-1:0]      cnt;
  logic [DIVIDEND_LEN-1:0] qmag;
  logic [DIVISOR_LEN-1:0]  vmag;
  logic [DIVISOR_LEN-1:0]  r;
  logic                    sq, sr, dz, ovf_p;

  logic [DIVIDEND_LEN-1:0] dd_abs, q_fix;
  logic [DIVISOR_LEN-1:0]  dv_abs, r_src, r_fix, qmag_rs;
  logic [DIVISOR_LEN:0]    t;
  logic                    ge;

  twos_abs #(.W(DIVIDEND_LEN)) u_abs_dd (.a(dividend), .neg(dividend[DIVIDEND_LEN-1]), .y(dd_abs));
  twos_abs #(.W(DIVISOR_LEN))  u_abs_dv (.a(divisor),  .neg(divisor[DIVISOR_LEN-1]),   .y(dv_abs));
  twos_abs #(.W(DIVIDEND_LEN)) u_fix_q  (.a(qmag),     .neg(sq),                        .y(q_fix));
  twos_abs #(.W(DIVISOR_LEN))  u_fix_r  (.a(r_src),    .neg(sr),                        .y(r_fix));

  // On divide by zero qmag still holds |dividend|; resizing the magnitude and
  // re-applying the sign reproduces the dividend truncated/sign-extended.
  generate
    if (DIVIDEND_LEN >= DIVISOR_LEN) begin : g_trunc
      assign qmag_rs = qmag[DIVISOR_LEN-1:0];
    end else begin : g_ext
      assign qmag_rs = {{(DIVISOR_LEN-DIVIDEND_LEN){1'b0}}, qmag};
    end
  endgenerate

  assign r_src = dz ? qmag_rs : r;
  assign t     = {r, qmag[DIVIDEND_LEN-1]};
  assign ge    = (t >= {1'b0, vmag});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      qmag     <= '0;
      vmag     <= '0;
      r        <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      dz       <= 1'b0;
      ovf_p    <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      fin      <= 1'b0;
    end else if (!arm) begin
      state    <= IDLE;
      fin      <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          qmag  <= dd_abs;
          vmag  <= dv_abs;
          sq    <= dividend[DIVIDEND_LEN-1] ^ divisor[DIVISOR_LEN-1];
          sr    <= dividend[DIVIDEND_LEN-1];
          r     <= '0;
          cnt   <= '0;
          dz    <= (divisor == '0);
          state <= (divisor == '0) ? FIX : ITER;
        end
        ITER: begin
          // r < |divisor| always, so the low DIVISOR_LEN bits suffice.
          r     <= ge ? (t[DIVISOR_LEN-1:0] - vmag) : t[DIVISOR_LEN-1:0];
          qmag  <= {qmag[DIVIDEND_LEN-2:0], ge};
          cnt   <= cnt + CNT_SIZ'(1);
          if (cnt == CNT_SIZ'(DIVIDEND_LEN-1)) state <= FIX;
        end
        FIX: begin
          qmag  <= dz ? '0 : q_fix;
          r     <= r_fix;
          ovf_p <= !dz && !sq && qmag[DIVIDEND_LEN-1];
          state <= DONE;
        end
        DONE: begin
          // Publish once; results are held until arm falls.
          if (!fin) begin
            quot     <= qmag;
            rem      <= r;
            div_zero <= dz;
            ovf      <= ovf_p;
            fin      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seqdiv.md
# seqdiv

Sequential signed integer divider for the control-loop datapath, computing quotient and remainder of a two's-complement dividend by a two's-complement divisor. It is the inverse companion to the control loop's sequential multiplier and uses the same level-sensitive `arm`/`fin` handshake, so both blocks can be sequenced identically by the loop controller. It uses a restoring shift-subtract algorithm on operand magnitudes, one quotient bit per cycle, with a sign fix-up pass. Results truncate toward zero.

## Interface
- `DIVIDEND_LEN`, 32, dividend and quotient width (signed)
- `DIVISOR_LEN`, 32, divisor and remainder width (signed)
- `CNT_SIZ`, 6, iteration counter width; must hold `DIVIDEND_LEN`
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `arm` in 1: level request; high starts and holds a division, low aborts and clears
- `dividend` in `DIVIDEND_LEN`: signed numerator, sampled when leaving IDLE
- `divisor` in `DIVISOR_LEN`: signed denominator, sampled when leaving IDLE
- `quot` out `DIVIDEND_LEN`: signed quotient, registered
- `rem` out `DIVISOR_LEN`: signed remainder, registered; sign follows dividend
- `div_zero` out 1: divisor was zero
- `ovf` out 1: quotient not representable (most-negative / -1)
- `fin` out 1: result valid; held until `arm` falls

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: `fin`=0. On `arm`=1:
  - latch unsigned magnitudes `|dividend|` (`DIVIDEND_LEN` bits, unsigned, so the most-negative value fits) and `|divisor|` (`DIVISOR_LEN` bits);
  - latch sign bits `sq = sign(dividend) ^ sign(divisor)` and `sr = sign(dividend)`;
  - clear the partial remainder (`DIVISOR_LEN+1` bits) and counter.
  - Go to FIX if the divisor is zero, else go to ITER.
- ITER, `DIVIDEND_LEN` cycles, MSB first:
  - `t = {r, qmag[MSB]}` and `qmag` shifts left.
  - If `t >= |divisor|`: `r = t - |divisor|` and shift in 1. Otherwise `r = t` and shift in 0.
  - After the last iteration, go to FIX.
- FIX, one cycle:
  - `quot = sq ? -qmag : qmag` and `rem = sr ? -r : r` (truncated to width).
  - `ovf = !sq & qmag[DIVIDEND_LEN-1]`; `quot` keeps the wrapped value.
  - If divide by zero: `quot=0`, `rem=dividend[DIVISOR_LEN-1:0]` (sign-extended if narrower), `div_zero=1`, `ovf=0`.
  - Go to DONE.
- DONE: `fin`=1. Stay while `arm`=1. On `arm`=0, go to IDLE.
- `arm`=0 in any state: go to IDLE on the next edge.
  - `fin`, `div_zero` and `ovf` clear.
  - `quot` and `rem` hold their last values.
  - No partial result is ever published.
- `div_zero` and `ovf` are valid only while `fin`=1.

## Timing
- Reset values: state IDLE, `fin`=0, `quot`=0, `rem`=0, `div_zero`=0, `ovf`=0, counter 0.
- Latency: call edge E the one that samples `arm`=1 in IDLE. `fin` rises after edge E+`DIVIDEND_LEN`+2 (34 edges by default). For divide by zero, `fin` rises after edge E+2.
- `quot`, `rem`, `div_zero` and `ovf` update on the same edge that `fin` rises.
- `fin` falls on the first edge sampling `arm`=0. A new division needs `arm` low for at least one edge.
- Operand changes after edge E are ignored.
- `rst` asserted mid-operation forces all reset values immediately, independent of `clk`. After release, the block waits for `arm`.

## Structure
- Shared control-loop package/header holds the state encoding localparams (IDLE/ITER/FIX/DONE) and the `arm`/`fin` handshake notes common with the multiplier.
- One natural sub-module: `twos_abs`, a parameterized width magnitude/negate helper. It is instantiated for the operand magnitudes and for the sign fix-up.
- The iteration datapath stays in the top module.

## Test plan
- 100 / 7 → `quot`=14, `rem`=2, flags 0, `fin` exactly 34 edges after arm.
- -100 / 7 → -14 r -2; 100 / -7 → -14 r 2; -100 / -7 → 14 r -2.
- 5 / 0 → `div_zero`=1, `quot`=0, `rem`=5, `fin` after 2 edges.
- 0x80000000 / -1 → `ovf`=1, `quot`=0x80000000, `rem`=0. Also 0x80000000 / 1 → `quot`=0x80000000, `ovf`=0.
- Drop `arm` after 10 edges of 1000/3 → IDLE next edge, `fin`=0, outputs unchanged. Re-arm 42/6 → 7 r 0 in 34 edges.
- Assert `rst` mid-ITER, off a clock edge → outputs zero immediately. After release with `arm` high, 9/4 → 2 r 1.
